// File: rtl/diff_integrator_16_bit_pkg.sv
// rtl/diff_integrator_16_bit_pkg.sv - shared widths, state encoding and clamp limits
package diff_integrator_16_bit_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam logic signed [DW-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DW-1:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/diff_integrator_16_bit_ovf_add.sv
// rtl/diff_integrator_16_bit_ovf_add.sv - 16-bit wrapping adder with signed overflow detect
module ovf_add_16_bit
  import diff_integrator_16_bit_pkg::*;
(
  input  logic [DW-1:0] i_base,
  input  logic [DW-1:0] i_delta,
  output logic [DW-1:0] o_sum,
  output logic          o_pos_ovf,
  output logic          o_neg_ovf
);

  logic [DW-1:0] w_sum;

  assign w_sum     = i_base + i_delta;
  assign o_sum     = w_sum;
  // Overflow only possible when both operands share a sign and the result flips it
  assign o_pos_ovf = ~i_base[DW-1] & ~i_delta[DW-1] &  w_sum[DW-1];
  assign o_neg_ovf =  i_base[DW-1] &  i_delta[DW-1] & ~w_sum[DW-1];

endmodule

// File: rtl/diff_integrator_16_bit.sv
// rtl/diff_integrator_16_bit.sv - delta-to-sample integrator, valid/ready both sides
// Optional clamp on overflow: DIFF_INTEG_SATURATE_EN.
module diff_integrator_16_bit
  import diff_integrator_16_bit_pkg::*;
#(
  parameter logic signed [DW-1:0] SEED   = 16'sd0,
  parameter bit                   STICKY = 1'b1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] delta,
  input  logic          load,
  input  logic [DW-1:0] load_value,
  input  logic          flag_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          OvP,
  output logic          OvN,
  output logic [1:0]    state_o
);

  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_out_data;
  logic          r_out_valid;
  logic          r_ovp;
  logic          r_ovn;
  logic          r_ready_en;
  state_t        r_state;

  state_t        w_state_nxt;
  logic [DW-1:0] w_base;
  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_result;
  logic          w_pos_ovf;
  logic          w_neg_ovf;
  logic          w_accept;
  logic          w_in_ready;

  // Held low for the first cycle after reset release so no delta lands mid-reset
  assign w_in_ready = r_ready_en & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_base     = load ? load_value : r_acc;

  ovf_add_16_bit u_add (
    .i_base    (w_base),
    .i_delta   (delta),
    .o_sum     (w_sum),
    .o_pos_ovf (w_pos_ovf),
    .o_neg_ovf (w_neg_ovf)
  );

`ifdef DIFF_INTEG_SATURATE_EN
  always_comb begin
    w_result = w_sum;
    if (w_pos_ovf) begin
      w_result = SAT_MAX;
    end else if (w_neg_ovf) begin
      w_result = SAT_MIN;
    end
  end
`else
  assign w_result = w_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= SEED;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ready_en  <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        r_acc       <= w_result;
        r_out_data  <= w_result;
        r_out_valid <= 1'b1;
      end else begin
        if (load) begin
          r_acc <= load_value;
        end
        if (out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovp <= 1'b0;
      r_ovn <= 1'b0;
    end else if (STICKY) begin
      // Set wins over a same-cycle clear
      r_ovp <= (r_ovp & ~flag_clr) | (w_accept & w_pos_ovf);
      r_ovn <= (r_ovn & ~flag_clr) | (w_accept & w_neg_ovf);
    end else if (w_accept) begin
      r_ovp <= w_pos_ovf;
      r_ovn <= w_neg_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_out_valid && !out_ready && in_valid) begin
          w_state_nxt = ST_STALL;
        end
      end
      ST_STALL: begin
        if (out_ready) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign OvP       = r_ovp;
  assign OvN       = r_ovn;
  assign state_o   = r_state;

endmodule
